// File: rtl/uart_pkg.sv
// Shared UART definitions: RX FSM encoding, parity selectors shared with TX,
// legal oversampling ratios and the default frame width.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // PAR_TYP encoding, identical on both ends of the link
    localparam logic PAR_ODD  = 1'b0;
    localparam logic PAR_EVEN = 1'b1;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam int unsigned P_WIDTH_DEFAULT = 8;

    // 2-of-3 vote used for mid-bit noise rejection
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversampling edge counter with three mid-bit samples and majority vote.
// bit_done flags edge Prescale-1, where sampled_bit holds the bit decision.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       enable,
    input  logic       RX_IN,
    input  logic [5:0] Prescale,
    output logic       sampled_bit,
    output logic       bit_done
);

    logic [5:0] edge_cnt;
    logic       smp0;
    logic       smp1;
    logic       smp2;
    logic [5:0] mid;
    logic [5:0] last;

    assign mid  = {1'b0, Prescale[5:1]};
    assign last = Prescale - 6'd1;

    // Edge counter runs while a frame is in flight and captures the mid-bit samples
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= 6'd0;
            smp0     <= 1'b0;
            smp1     <= 1'b0;
            smp2     <= 1'b0;
        end else begin
            if (!enable || edge_cnt == last) begin
                edge_cnt <= 6'd0;
            end else begin
                edge_cnt <= edge_cnt + 6'd1;
            end
            if (enable && edge_cnt == mid - 6'd1) smp0 <= RX_IN;
            if (enable && edge_cnt == mid)        smp1 <= RX_IN;
            if (enable && edge_cnt == mid + 6'd1) smp2 <= RX_IN;
        end
    end

    // All three samples are registered well before the last edge of the bit
    always_comb begin
        sampled_bit = majority3(smp0, smp1, smp2);
        bit_done    = enable && (edge_cnt == last);
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit validation, LSB-first deserialization, optional
// parity and stop-bit check, single-cycle result pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned P_Width = P_WIDTH_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic [5:0]         Prescale,
    output logic [P_Width-1:0] P_DATA,
    output logic               DATA_VALID,
    output logic               PAR_ERR,
    output logic               STP_ERR
);

    localparam int unsigned BIT_CNT_W = (P_Width > 1) ? $clog2(P_Width) : 1;

    rx_state_e            state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [P_Width-1:0]   shift_reg;
    logic                 par_bad;
    logic                 start_det;
    logic                 enable;
    logic                 exp_par;
    logic                 sampled_bit;
    logic                 bit_done;

    // Start edge is accepted in the very cycle IDLE sees the line low
    always_comb begin
        start_det = (state == IDLE) && !RX_IN;
        enable    = (state != IDLE) || start_det;
        exp_par   = (PAR_TYP == PAR_EVEN) ? ^shift_reg : ~^shift_reg;
    end

    uart_rx_sampler u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .enable      (enable),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .sampled_bit (sampled_bit),
        .bit_done    (bit_done)
    );

    // Frame FSM with deserializer and registered result pulses
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bad    <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_det) begin
                        state   <= START;
                        bit_cnt <= '0;
                        par_bad <= 1'b0;
                    end
                end
                START: begin
                    // A high majority means the falling edge was only a glitch
                    if (bit_done) state <= sampled_bit ? IDLE : DATA;
                end
                DATA: begin
                    if (bit_done) begin
                        shift_reg[bit_cnt] <= sampled_bit;
                        if (bit_cnt == BIT_CNT_W'(P_Width - 1)) begin
                            bit_cnt <= '0;
                            state   <= PAR_EN ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        par_bad <= (sampled_bit != exp_par);
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        STP_ERR <= ~sampled_bit;
                        PAR_ERR <= par_bad;
                        // P_DATA only ever holds a frame that passed every check
                        if (sampled_bit && !par_bad) begin
                            P_DATA     <= shift_reg;
                            DATA_VALID <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames with hand-computed pulse cycles and data.
module tb_uart_rx;
    import uart_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;

    int         dv_cyc_q[$];
    logic [7:0] dv_byte_q[$];
    int         pe_cyc_q[$];
    int         se_cyc_q[$];

    uart_rx #(.P_Width(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Log every pulse with the cycle it is visible in
    always @(negedge CLK) begin
        if (DATA_VALID) begin
            dv_cyc_q.push_back(cyc);
            dv_byte_q.push_back(P_DATA);
        end
        if (PAR_ERR) pe_cyc_q.push_back(cyc);
        if (STP_ERR) se_cyc_q.push_back(cyc);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1 RX_IN = 1'b1;
        end
    endtask

    // Drives one frame; limit >= 0 truncates it. t0 marks cycle 0 (start edge).
    task automatic drive_frame(input logic [7:0] data, input logic par_bit,
                               input logic stop_bit, input int limit, output int t0);
        int         p;
        int         nb;
        int         total;
        logic [10:0] bits;
        p    = int'(Prescale);
        nb   = PAR_EN ? 11 : 10;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = data[i];
        if (PAR_EN) bits[9] = par_bit;
        bits[nb-1] = stop_bit;
        total = nb * p;
        if (limit >= 0 && limit < total) total = limit;
        t0 = 0;
        for (int k = 0; k < total; k++) begin
            @(posedge CLK);
            #1 RX_IN = bits[k/p];
            if (k == 0) t0 = cyc;
        end
    endtask

    initial begin
        int t0;
        int t1;
        int bd;
        int bp;
        int bs;

        // Reset state
        #3;
        check_eq("rst_dv", 32'(DATA_VALID), 32'd0);
        check_eq("rst_pe", 32'(PAR_ERR), 32'd0);
        check_eq("rst_se", 32'(STP_ERR), 32'd0);
        check_eq("rst_pdata", 32'(P_DATA), 32'h00);
        check_eq("rst_state", 32'(dut.state), 32'(IDLE));
        @(posedge CLK);
        #1 RST = 1'b1;
        idle(4);

        // 0xA5, even parity, parity bit 0: good frame at cycle 88
        Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        bd = dv_cyc_q.size(); bp = pe_cyc_q.size(); bs = se_cyc_q.size();
        drive_frame(8'hA5, 1'b0, 1'b1, -1, t0);
        idle(4);
        check_eq("even_dv_cnt", 32'(dv_cyc_q.size() - bd), 32'd1);
        check_eq("even_dv_cyc", 32'((dv_cyc_q.size() > bd) ? dv_cyc_q[bd] - t0 : -1), 32'd88);
        check_eq("even_pdata", 32'(P_DATA), 32'hA5);
        check_eq("even_pe_cnt", 32'(pe_cyc_q.size() - bp), 32'd0);
        check_eq("even_se_cnt", 32'(se_cyc_q.size() - bs), 32'd0);

        // Same frame with odd parity: expected parity 1, line sends 0
        PAR_TYP = 1'b0;
        bd = dv_cyc_q.size(); bp = pe_cyc_q.size(); bs = se_cyc_q.size();
        drive_frame(8'hA5, 1'b0, 1'b1, -1, t0);
        idle(4);
        check_eq("odd_pe_cnt", 32'(pe_cyc_q.size() - bp), 32'd1);
        check_eq("odd_pe_cyc", 32'((pe_cyc_q.size() > bp) ? pe_cyc_q[bp] - t0 : -1), 32'd88);
        check_eq("odd_dv_cnt", 32'(dv_cyc_q.size() - bd), 32'd0);
        check_eq("odd_se_cnt", 32'(se_cyc_q.size() - bs), 32'd0);
        check_eq("odd_pdata_hold", 32'(P_DATA), 32'hA5);

        // Prescale 16, no parity, 0x3C with stop bit 0
        Prescale = 6'd16; PAR_EN = 1'b0;
        bd = dv_cyc_q.size(); bp = pe_cyc_q.size(); bs = se_cyc_q.size();
        drive_frame(8'h3C, 1'b0, 1'b0, -1, t0);
        idle(4);
        check_eq("stp_se_cnt", 32'(se_cyc_q.size() - bs), 32'd1);
        check_eq("stp_se_cyc", 32'((se_cyc_q.size() > bs) ? se_cyc_q[bs] - t0 : -1), 32'd160);
        check_eq("stp_dv_cnt", 32'(dv_cyc_q.size() - bd), 32'd0);
        check_eq("stp_pe_cnt", 32'(pe_cyc_q.size() - bp), 32'd0);
        check_eq("stp_pdata_hold", 32'(P_DATA), 32'hA5);

        // Start glitch: low for 2 cycles, then high
        Prescale = 6'd8; PAR_EN = 1'b0;
        bd = dv_cyc_q.size(); bp = pe_cyc_q.size(); bs = se_cyc_q.size();
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK);
            #1 RX_IN = (k < 2) ? 1'b0 : 1'b1;
        end
        check_eq("glitch_in_start", 32'(dut.state), 32'(START));
        @(posedge CLK);
        #1;
        check_eq("glitch_idle_c8", 32'(dut.state), 32'(IDLE));
        idle(3);
        check_eq("glitch_no_pulse",
                 32'((dv_cyc_q.size() - bd) + (pe_cyc_q.size() - bp) + (se_cyc_q.size() - bs)),
                 32'd0);
        drive_frame(8'h81, 1'b0, 1'b1, -1, t0);
        idle(4);
        check_eq("after_glitch_dv_cnt", 32'(dv_cyc_q.size() - bd), 32'd1);
        check_eq("after_glitch_dv_cyc",
                 32'((dv_cyc_q.size() > bd) ? dv_cyc_q[bd] - t0 : -1), 32'd80);
        check_eq("after_glitch_byte", 32'((dv_byte_q.size() > bd) ? dv_byte_q[bd] : 8'hEE),
                 32'h81);

        // Back-to-back frames at Prescale 32
        Prescale = 6'd32; PAR_EN = 1'b0;
        bd = dv_cyc_q.size();
        drive_frame(8'h00, 1'b0, 1'b1, -1, t0);
        drive_frame(8'hFF, 1'b0, 1'b1, -1, t1);
        idle(4);
        check_eq("b2b_dv_cnt", 32'(dv_cyc_q.size() - bd), 32'd2);
        check_eq("b2b_second_start", 32'(t1 - t0), 32'd320);
        check_eq("b2b_cyc0", 32'((dv_cyc_q.size() > bd) ? dv_cyc_q[bd] - t0 : -1), 32'd320);
        check_eq("b2b_byte0", 32'((dv_byte_q.size() > bd) ? dv_byte_q[bd] : 8'hEE), 32'h00);
        check_eq("b2b_cyc1",
                 32'((dv_cyc_q.size() > bd + 1) ? dv_cyc_q[bd+1] - t0 : -1), 32'd640);
        check_eq("b2b_byte1",
                 32'((dv_byte_q.size() > bd + 1) ? dv_byte_q[bd+1] : 8'hEE), 32'hFF);

        // Reset in the middle of data bit 4, then a clean 0x5A frame
        Prescale = 6'd8; PAR_EN = 1'b0;
        bd = dv_cyc_q.size(); bp = pe_cyc_q.size(); bs = se_cyc_q.size();
        drive_frame(8'h5A, 1'b0, 1'b1, 43, t0);
        #2 RST = 1'b0;
        #1;
        check_eq("midrst_pdata", 32'(P_DATA), 32'h00);
        check_eq("midrst_outs", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'd0);
        check_eq("midrst_state", 32'(dut.state), 32'(IDLE));
        RX_IN = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        idle(3);
        check_eq("midrst_state_rel", 32'(dut.state), 32'(IDLE));
        check_eq("midrst_no_pulse",
                 32'((dv_cyc_q.size() - bd) + (pe_cyc_q.size() - bp) + (se_cyc_q.size() - bs)),
                 32'd0);
        drive_frame(8'h5A, 1'b0, 1'b1, -1, t0);
        idle(4);
        check_eq("postrst_dv_cnt", 32'(dv_cyc_q.size() - bd), 32'd1);
        check_eq("postrst_dv_cyc",
                 32'((dv_cyc_q.size() > bd) ? dv_cyc_q[bd] - t0 : -1), 32'd80);
        check_eq("postrst_pdata", 32'(P_DATA), 32'h5A);
        check_eq("postrst_errs", 32'((pe_cyc_q.size() - bp) + (se_cyc_q.size() - bs)), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
